// File: rtl/alp_resp_checker.sv
// Compares ALP OUT_0/OUT_1/ERRreg against a preloaded table of expected responses and reports pass/fail.
// Optional ALP_CHK_STOP_ON_FAIL_EN: the first mismatch ends the run immediately.
module alp_resp_checker #(
  parameter int W     = 4,
  parameter int DEPTH = 101,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2*W:0]  wr_data,
  input  logic [AW-1:0] last_idx,
  input  logic          start,
  input  logic          vec_valid,
  input  logic [W-1:0]  out_0,
  input  logic [W-1:0]  out_1,
  input  logic          err_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          mismatch,
  output logic [15:0]   errors,
  output logic [AW-1:0] vectornum,
  output logic [AW-1:0] first_fail
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  state_t        state;
  logic [2*W:0]  tbl [DEPTH];
  logic [AW-1:0] last_q;
  logic [2*W:0]  exp_ent;
  logic          cmp;
  logic          miss;
  logic          stop;
  logic [15:0]   errors_nxt;

  // Table has no reset so expected contents survive a reset of the checker.
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && wr_en && wr_addr <= LAST_MAX)
      tbl[wr_addr] <= wr_data;
  end

  always_comb begin
    exp_ent    = tbl[vectornum];
    cmp        = (state == RUN) && vec_valid;
    miss       = cmp && ({out_0, out_1, err_in} != exp_ent);
    errors_nxt = errors;
    if (miss && errors != 16'hFFFF)
      errors_nxt = errors + 16'd1;
`ifdef ALP_CHK_STOP_ON_FAIL_EN
    stop = cmp && ((vectornum == last_q) || miss);
`else
    stop = cmp && (vectornum == last_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      errors     <= '0;
      vectornum  <= '0;
      first_fail <= '0;
      last_q     <= '0;
    end else begin
      mismatch <= miss;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            errors     <= '0;
            vectornum  <= '0;
            first_fail <= '0;
            last_q     <= (last_idx > LAST_MAX) ? LAST_MAX : last_idx;
          end
        end
        RUN: begin
          if (cmp) begin
            vectornum <= vectornum + 1'b1;
            errors    <= errors_nxt;
            // errors is cleared at start and never returns to 0, so it marks the first failure.
            if (miss && errors == 16'd0)
              first_fail <= vectornum;
          end
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (errors_nxt == 16'd0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
